// File: rtl/uart_pkg.sv
// uart_pkg: shared UART 8N1 constants, FSM state type and baud divisor helper.
package uart_pkg;
    localparam logic [1:0] BAUD_SEL_9600   = 2'b00;
    localparam logic [1:0] BAUD_SEL_19200  = 2'b01;
    localparam logic [1:0] BAUD_SEL_57600  = 2'b10;
    localparam logic [1:0] BAUD_SEL_115200 = 2'b11;
    localparam int DATA_BITS     = 8;
    localparam int FRAME_BITS    = 10;
    localparam int IMG_HDR_WORDS = 4;
    typedef enum logic [2:0] {IDLE, FETCH_A, FETCH_B, SEND0, SEND1, SEND2, FIN} state_e;
    function automatic logic [31:0] baud_div(input int clk_freq, input logic [1:0] sel);
        return 32'(clk_freq / (sel == BAUD_SEL_9600  ? 9600  :
                               sel == BAUD_SEL_19200 ? 19200 :
                               sel == BAUD_SEL_57600 ? 57600 : 115200));
    endfunction
endpackage

// File: rtl/uart_img_tx_if.sv
// uart_img_tx_if: SRAM read port between the image dumper and the read arbiter.
interface uart_img_tx_if #(parameter int ADDR_W = 19);
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_ack;
    logic [15:0]       rd_data;
    modport master(output rd_req, rd_addr, input rd_ack, rd_data);
    modport slave(input rd_req, rd_addr, output rd_ack, rd_data);
endinterface

// File: rtl/uart_tx_byte.sv
// uart_tx_byte: 8N1 byte serializer with a registered line output.
module uart_tx_byte
    import uart_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          div,
    input  logic                 load,
    input  logic [DATA_BITS-1:0] byte_in,
    output logic                 tx_out,
    output logic                 ready
);
    logic [FRAME_BITS-2:0] shift_q;
    logic [3:0]            bits_q;
    logic [31:0]           cnt_q;
    logic                  act_q, tx_q, last;
    // ready already in the final stop-bit cycle so bytes can go out back to back
    assign last   = cnt_q == 32'd0 && bits_q == 4'd0;
    assign ready  = !act_q || last;
    assign tx_out = tx_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_q    <= 1'b1;
            act_q   <= 1'b0;
            shift_q <= '1;
            bits_q  <= '0;
            cnt_q   <= '0;
        end else if (load && ready) begin
            tx_q    <= 1'b0;
            shift_q <= {1'b1, byte_in};
            bits_q  <= 4'(FRAME_BITS - 1);
            cnt_q   <= div - 32'd1;
            act_q   <= 1'b1;
        end else if (act_q) begin
            if (last) begin
                act_q <= 1'b0;
                tx_q  <= 1'b1;
            end else if (cnt_q == 32'd0) begin
                tx_q    <= shift_q[0];
                shift_q <= {1'b1, shift_q[FRAME_BITS-2:1]};
                bits_q  <= bits_q - 4'd1;
                cnt_q   <= div - 32'd1;
            end else begin
                cnt_q <= cnt_q - 32'd1;
            end
        end
    end
endmodule

// File: rtl/uart_img_tx.sv
// uart_img_tx: reads a stored image out of SRAM and streams it over UART,
// packing two 12-bit words into three bytes exactly as the loader expects.
module uart_img_tx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 100_000_000,
    parameter int ADDR_W   = 19
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [1:0]           brate_selection,
    uart_img_tx_if.master        sram,
    output logic                 tx_out,
    output logic                 busy,
    output logic                 done
);
    localparam logic [31:0] N_MAX = 32'(1) << ADDR_W;
    state_e          state_q, state_d;
    logic [ADDR_W:0] addr_q, addr_d, n_q, n_d;
    logic [11:0]     a_q, a_d, b_q, b_d;
    logic [31:0]     div_q, div_d, prod;
    logic            busy_q, done_q, load, ready, unused_hi;
    logic [7:0]      byte_out;
    assign unused_hi    = ^sram.rd_data[15:12];
    assign prod         = 32'(a_q) * 32'(sram.rd_data[11:0]) + 32'(IMG_HDR_WORDS);
    assign sram.rd_addr = addr_q[ADDR_W-1:0];
    assign busy         = busy_q;
    assign done         = done_q;
    assign byte_out     = state_q == SEND0 ? a_q[7:0] :
                          state_q == SEND1 ? {b_q[3:0], a_q[11:8]} : b_q[11:4];
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        n_d         = n_q;
        a_d         = a_q;
        b_d         = b_q;
        div_d       = div_q;
        sram.rd_req = 1'b0;
        load        = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                state_d = FETCH_A;
                addr_d  = '0;
                div_d   = baud_div(CLK_FREQ, brate_selection);
            end
            FETCH_A: begin
                sram.rd_req = 1'b1;
                if (sram.rd_ack) begin
                    a_d     = sram.rd_data[11:0];
                    addr_d  = addr_q + 1'b1;
                    state_d = FETCH_B;
                end
            end
            // word0/word1 are always sent; the length check only guards pixel words
            FETCH_B: if (addr_q > (ADDR_W+1)'(1) && addr_q >= n_q) begin
                b_d     = '0;
                state_d = SEND0;
            end else begin
                sram.rd_req = 1'b1;
                if (sram.rd_ack) begin
                    b_d     = sram.rd_data[11:0];
                    addr_d  = addr_q + 1'b1;
                    state_d = SEND0;
                    if (addr_q == (ADDR_W+1)'(1))
                        n_d = prod > N_MAX ? N_MAX[ADDR_W:0] : prod[ADDR_W:0];
                end
            end
            SEND0: begin
                load    = 1'b1;
                state_d = ready ? SEND1 : SEND0;
            end
            SEND1: begin
                load    = 1'b1;
                state_d = ready ? SEND2 : SEND1;
            end
            SEND2: begin
                load    = 1'b1;
                state_d = !ready ? SEND2 : addr_q < n_q ? FETCH_A : FIN;
            end
            FIN: state_d = ready ? IDLE : FIN;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            n_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            div_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            n_q     <= n_d;
            a_q     <= a_d;
            b_q     <= b_d;
            div_q   <= div_d;
            busy_q  <= state_d != IDLE;
            done_q  <= state_q == FIN && ready;
        end
    end
    uart_tx_byte u_tx (
        .clk     (clk),
        .rst     (rst),
        .div     (div_q),
        .load    (load),
        .byte_in (byte_out),
        .tx_out  (tx_out),
        .ready   (ready)
    );
endmodule

// File: tb/tb_uart_img_tx.sv
// tb_uart_img_tx: directed bench with an SRAM responder and a UART receiver model.
module tb_uart_img_tx;
    import uart_pkg::*;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic [1:0] sel = 2'b11;
    logic tx_out, busy, done;
    int checks = 0;
    int failures = 0;
    int exp_div = 8;
    int cyc = 0;
    int acks = 0;
    int dones = 0;
    int stall_addr = -1;
    int stall_left = 0;
    logic [15:0] mem [16];
    logic [7:0] rx_bytes [$];
    logic [7:0] exp_q [$];
    int rx_starts [$];

    uart_img_tx_if #(.ADDR_W(19)) sram ();
    uart_img_tx #(.CLK_FREQ(1_000_000), .ADDR_W(19)) dut (
        .clk(clk), .rst(rst), .start(start), .brate_selection(sel),
        .sram(sram), .tx_out(tx_out), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // SRAM responder: one cycle of latency, optional stall on one address
    initial begin
        sram.rd_ack = 1'b0;
        sram.rd_data = '0;
        forever begin
            @(negedge clk);
            if (sram.rd_ack) sram.rd_ack = 1'b0;
            else if (sram.rd_req && int'(sram.rd_addr) == stall_addr && stall_left > 0) stall_left--;
            else if (sram.rd_req) begin
                sram.rd_ack = 1'b1;
                sram.rd_data = mem[sram.rd_addr[3:0]];
                acks++;
            end
        end
    end

    // UART receiver sampling mid-bit at the expected divisor
    initial begin
        int cnt, k;
        bit act;
        logic prev;
        logic [7:0] sh;
        act = 0; prev = 1'b1; cnt = 0; sh = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (done) dones++;
            if (rst) act = 0;
            else if (!act) begin
                if (prev && !tx_out) begin
                    act = 1; cnt = 0;
                    rx_starts.push_back(cyc);
                end
            end else begin
                cnt++;
                if (cnt > exp_div && (cnt - exp_div / 2) % exp_div == 0) begin
                    k = (cnt - exp_div / 2) / exp_div;
                    if (k <= 8) sh = {tx_out, sh[7:1]};
                    else begin
                        act = 0;
                        check("stop_bit", 32'(tx_out), 1);
                        rx_bytes.push_back(sh);
                    end
                end
            end
            prev = tx_out;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic new_frame(input logic [15:0] w0, w1, w2, w3, w4, w5);
        mem[0] = w0; mem[1] = w1; mem[2] = w2; mem[3] = w3; mem[4] = w4; mem[5] = w5;
        rx_bytes.delete();
        rx_starts.delete();
        acks = 0;
    endtask

    task automatic wait_done(input int limit);
        int target = dones + 1;
        for (int i = 0; i < limit && dones < target; i++) @(negedge clk);
        check("done_seen", 32'(dones >= target), 1);
    endtask

    task automatic check_bytes(input string tag);
        check({tag, "_count"}, 32'(rx_bytes.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < rx_bytes.size(); i++)
            check($sformatf("%s_b%0d", tag, i), 32'(rx_bytes[i]), 32'(exp_q[i]));
    endtask

    initial begin
        int d0;
        for (int i = 0; i < 16; i++) mem[i] = '0;
        tick(3);
        rst = 1'b0;
        @(negedge clk);
        check("rst_tx", 32'(tx_out), 1);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_req", 32'(sram.rd_req), 0);
        check("rst_addr", 32'(sram.rd_addr), 0);
        check("div_115200", baud_div(100_000_000, 2'b11), 868);
        check("div_57600", baud_div(100_000_000, 2'b10), 1736);
        check("div_19200", baud_div(100_000_000, 2'b01), 5208);
        check("div_9600", baud_div(100_000_000, 2'b00), 10416);

        // 2x1 image; upper nibble of pixel word must be ignored
        new_frame(16'd2, 16'd1, 16'd0, 16'd0, 16'hFABC, 16'h0123);
        sel = 2'b11; exp_div = 8; d0 = dones;
        pulse_start();
        check("t2_busy", 32'(busy), 1);
        wait_done(3000);
        exp_q = '{8'h02, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00, 8'hBC, 8'h3A, 8'h12};
        check_bytes("t2");
        check("t2_period", 32'(rx_starts[1] - rx_starts[0]), 80);
        check("t2_acks", 32'(acks), 6);
        tick(5);
        check("t2_done_once", 32'(dones), 32'(d0 + 1));
        check("t2_idle", 32'(busy), 0);

        // 1x1 image: odd N, padded last word
        new_frame(16'd1, 16'd1, 16'd0, 16'd0, 16'h0F0F, 16'h0777);
        pulse_start();
        wait_done(3000);
        exp_q = '{8'h01, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00, 8'h0F, 8'h0F, 8'h00};
        check_bytes("t3");
        check("t3_acks", 32'(acks), 5);

        // arbiter stall on the first pixel word
        new_frame(16'd2, 16'd1, 16'd0, 16'd0, 16'h0ABC, 16'h0123);
        stall_addr = 4; stall_left = 5000;
        pulse_start();
        for (int i = 0; i < 6000 && stall_left > 2500; i++) @(negedge clk);
        check("t4_req", 32'(sram.rd_req), 1);
        check("t4_addr", 32'(sram.rd_addr), 4);
        check("t4_tx_high", 32'(tx_out), 1);
        check("t4_bytes_so_far", 32'(rx_bytes.size()), 6);
        wait_done(8000);
        exp_q = '{8'h02, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00, 8'hBC, 8'h3A, 8'h12};
        check_bytes("t4");
        stall_addr = -1;

        // start and brate_selection changes mid-frame are ignored
        new_frame(16'd2, 16'd1, 16'd0, 16'd0, 16'h0ABC, 16'h0123);
        pulse_start();
        tick(100);
        sel = 2'b00;
        pulse_start();
        tick(200);
        pulse_start();
        wait_done(3000);
        check_bytes("t5");
        check("t5_period", 32'(rx_starts[4] - rx_starts[3]), 80);
        check("t5_acks", 32'(acks), 6);
        tick(20);
        check("t5_no_restart", 32'(busy), 0);

        // 9600 baud with W=0 -> header only
        new_frame(16'd0, 16'd5, 16'd7, 16'd9, 16'h0123, 16'h0456);
        exp_div = 104;
        pulse_start();
        wait_done(12000);
        exp_q = '{8'h00, 8'h50, 8'h00, 8'h07, 8'h90, 8'h00};
        check_bytes("t6");
        check("t6_period", 32'(rx_starts[1] - rx_starts[0]), 1040);
        check("t6_acks", 32'(acks), 4);

        // reset in the middle of a start bit
        new_frame(16'd2, 16'd1, 16'd0, 16'd0, 16'h0ABC, 16'h0123);
        sel = 2'b11; exp_div = 8;
        pulse_start();
        for (int i = 0; i < 200 && tx_out; i++) @(negedge clk);
        check("t1_tx_low", 32'(tx_out), 0);
        tick(2);
        rst = 1'b1;
        tick(1);
        check("t1_tx", 32'(tx_out), 1);
        check("t1_busy", 32'(busy), 0);
        check("t1_req", 32'(sram.rd_req), 0);
        check("t1_done", 32'(done), 0);
        check("t1_addr", 32'(sram.rd_addr), 0);
        tick(2);
        rst = 1'b0;
        tick(50);
        check("t1_stays_idle", 32'(busy), 0);
        check("t1_line_idle", 32'(tx_out), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
